// File: rtl/xgmii_frame_gen.sv
// XGMII test-frame generator on the 156.25 MHz transmit clock.
// Builds complete Ethernet frames at run time from the sampled configuration.
// Each frame carries the programmed MACs and EtherType, a 32-bit sequence
// number, an incrementing payload and a CRC-32 FCS.
// Frames are emitted as PRE / DATA / IFG words, and every output is registered.

module xgmii_frame_gen #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int LEN_W   = 14
) (
  input  logic             clk156,
  input  logic             sys_rst_n,
  input  logic             enable,
  input  logic [31:0]      frame_count,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [7:0]       ifg_words,
  input  logic [47:0]      dst_mac,
  input  logic [47:0]      src_mac,
  input  logic [15:0]      ethertype,
  output logic [63:0]      xgmii_txd,
  output logic [7:0]       xgmii_txc,
  output logic             busy,
  output logic             done,
  output logic [31:0]      frames_sent
);

  // Byte offsets within a frame need one extra bit.
  // The terminate word can run past L by up to 7 lanes.
  localparam int KW = LEN_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_IFG  = 2'd3;

  localparam logic [63:0] IDLE_WORD     = 64'h0707_0707_0707_0707;
  localparam logic [63:0] PRE_WORD      = 64'hD555_5555_5555_55FB;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  // One byte of the reflected IEEE 802.3 CRC-32, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc_in ^ {24'h0, data};
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

  // Sequential state.
  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       ifg_q, ifg_d;
  logic [7:0]       ifg_left_q, ifg_left_d;
  logic [47:0]      dst_q, dst_d;
  logic [47:0]      src_q, src_d;
  logic [15:0]      etype_q, etype_d;
  logic [31:0]      count_q, count_d;
  logic [31:0]      seq_q, seq_d;
  logic [KW-1:0]    base_q, base_d;
  logic [31:0]      crc_q, crc_d;
  logic [31:0]      frames_sent_q, frames_sent_d;
  logic             done_q, done_d;
  logic             end_pend_q, end_pend_d;
  logic             done_pend_q, done_pend_d;
  logic             busy_q, busy_d;
  logic [63:0]      txd_q, txd_d;
  logic [7:0]       txc_q, txc_d;

  // Combinational helpers.
  logic [LEN_W-1:0] len_clamped;
  logic [KW-1:0]    len_k;
  logic [KW-1:0]    fcs_start;
  logic [KW-1:0]    lane_k;
  logic [143:0]     hdr;
  logic [7:0]       byte_v;
  logic [1:0]       fcs_idx;
  logic [31:0]      crc_acc;
  logic [31:0]      fcs;
  logic [63:0]      data_txd;
  logic [7:0]       data_txc;
  logic             last_word;
  logic             start;
  logic             reached;
  logic             load_cfg;
  logic [31:0]      next_seq;
  logic [31:0]      frames_sent_inc;

  // Clamp the requested length into the legal frame range.
  always_comb begin
    if (frame_len < MIN_L) begin
      len_clamped = MIN_L;
    end else if (frame_len > MAX_L) begin
      len_clamped = MAX_L;
    end else begin
      len_clamped = frame_len;
    end
  end

  // Assemble the current data word.
  // Header and payload lanes feed the CRC first, so the FCS lanes in the
  // same word see the finished CRC value.
  always_comb begin
    // NOTE: every variable gets a default at the top of a combinational block;
    // a path that leaves one unassigned would infer a latch.
    hdr       = {dst_q, src_q, etype_q, seq_q};
    len_k     = KW'(len_q);
    fcs_start = len_k - KW'(4);
    lane_k    = '0;
    byte_v    = '0;
    fcs_idx   = '0;
    crc_acc   = crc_q;
    data_txd  = '0;
    data_txc  = '0;

    for (int i = 0; i < 8; i++) begin
      lane_k = base_q + KW'(i);
      byte_v = 8'h00;
      if (lane_k < fcs_start) begin
        if (lane_k < KW'(18)) begin
          for (int j = 0; j < 18; j++) begin
            if (lane_k[4:0] == 5'(j)) byte_v = hdr[143-8*j -: 8];
          end
        end else begin
          byte_v = 8'(lane_k - KW'(18));
        end
        data_txd[8*i +: 8] = byte_v;
        crc_acc = crc32_byte(crc_acc, byte_v);
      end
    end

    fcs = ~crc_acc;

    for (int i = 0; i < 8; i++) begin
      lane_k = base_q + KW'(i);
      if (lane_k >= fcs_start && lane_k < len_k) begin
        fcs_idx = 2'(lane_k - fcs_start);
        case (fcs_idx)
          2'd0:    data_txd[8*i +: 8] = fcs[7:0];
          2'd1:    data_txd[8*i +: 8] = fcs[15:8];
          2'd2:    data_txd[8*i +: 8] = fcs[23:16];
          default: data_txd[8*i +: 8] = fcs[31:24];
        endcase
      end else if (lane_k == len_k) begin
        data_txd[8*i +: 8] = 8'hFD;
        data_txc[i]        = 1'b1;
      end else if (lane_k > len_k) begin
        data_txd[8*i +: 8] = 8'h07;
        data_txc[i]        = 1'b1;
      end
    end

    last_word = (base_q + KW'(7)) >= len_k;
  end

  // Frame sequencing, run bookkeeping and the next registered output word.
  // The frame that ends in IFG is counted one edge later. That edge is the
  // one that retires the last idle word from the outputs.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    ifg_d         = ifg_q;
    ifg_left_d    = ifg_left_q;
    dst_d         = dst_q;
    src_d         = src_q;
    etype_d       = etype_q;
    count_d       = count_q;
    seq_d         = seq_q;
    base_d        = base_q;
    crc_d         = crc_q;
    frames_sent_d = frames_sent_q;
    done_d        = done_q;
    end_pend_d    = 1'b0;
    done_pend_d   = 1'b0;
    busy_d        = (state_q != ST_IDLE);
    txd_d         = IDLE_WORD;
    txc_d         = 8'hFF;
    load_cfg      = 1'b0;
    frames_sent_inc = frames_sent_q + 32'd1;
    next_seq      = frames_sent_q;
    reached       = 1'b0;
    start         = 1'b0;

    if (end_pend_q) begin
      frames_sent_d = frames_sent_inc;
      if (done_pend_q) done_d = 1'b1;
    end else if (state_q == ST_IDLE && !enable) begin
      frames_sent_d = '0;
      done_d        = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        start = enable && !done_q && !end_pend_q &&
                (frame_count == 32'd0 || frames_sent_q < frame_count);
        if (start) begin
          state_d  = ST_PRE;
          load_cfg = 1'b1;
          next_seq = frames_sent_q;
        end
      end
      ST_PRE: begin
        txd_d   = PRE_WORD;
        txc_d   = 8'h01;
        base_d  = '0;
        crc_d   = 32'hFFFF_FFFF;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        txd_d  = data_txd;
        txc_d  = data_txc;
        crc_d  = crc_acc;
        base_d = base_q + KW'(8);
        if (last_word) begin
          state_d    = ST_IFG;
          ifg_left_d = (ifg_q == 8'd0) ? 8'd0 : ifg_q - 8'd1;
        end
      end
      default: begin
        if (ifg_left_q != 8'd0) begin
          ifg_left_d = ifg_left_q - 8'd1;
        end else begin
          reached     = (count_q != 32'd0) && (frames_sent_inc == count_q);
          end_pend_d  = 1'b1;
          done_pend_d = reached;
          if (enable && !reached) begin
            state_d  = ST_PRE;
            load_cfg = 1'b1;
            next_seq = frames_sent_inc;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase

    if (load_cfg) begin
      len_d   = len_clamped;
      ifg_d   = ifg_words;
      dst_d   = dst_mac;
      src_d   = src_mac;
      etype_d = ethertype;
      count_d = frame_count;
      seq_d   = next_seq;
    end
  end

  // State and output registers; reset forces idle words at once.
  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= ST_IDLE;
      len_q         <= MIN_L;
      ifg_q         <= '0;
      ifg_left_q    <= '0;
      dst_q         <= '0;
      src_q         <= '0;
      etype_q       <= '0;
      count_q       <= '0;
      seq_q         <= '0;
      base_q        <= '0;
      crc_q         <= 32'hFFFF_FFFF;
      frames_sent_q <= '0;
      done_q        <= 1'b0;
      end_pend_q    <= 1'b0;
      done_pend_q   <= 1'b0;
      busy_q        <= 1'b0;
      txd_q         <= IDLE_WORD;
      txc_q         <= 8'hFF;
    end else begin
      // NOTE: non-blocking assignments here, so every flop samples the
      // pre-edge value of the others regardless of statement order.
      state_q       <= state_d;
      len_q         <= len_d;
      ifg_q         <= ifg_d;
      ifg_left_q    <= ifg_left_d;
      dst_q         <= dst_d;
      src_q         <= src_d;
      etype_q       <= etype_d;
      count_q       <= count_d;
      seq_q         <= seq_d;
      base_q        <= base_d;
      crc_q         <= crc_d;
      frames_sent_q <= frames_sent_d;
      done_q        <= done_d;
      end_pend_q    <= end_pend_d;
      done_pend_q   <= done_pend_d;
      busy_q        <= busy_d;
      txd_q         <= txd_d;
      txc_q         <= txc_d;
    end
  end

  assign xgmii_txd   = txd_q;
  assign xgmii_txc   = txc_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frames_sent = frames_sent_q;

endmodule

// File: tb/tb_xgmii_frame_gen.sv
// Directed testbench for xgmii_frame_gen.
// Expected frames are rebuilt byte by byte from the programmed fields, with a
// software CRC-32 model for the FCS.

`timescale 1ns/1ps

module tb_xgmii_frame_gen;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;
  localparam int LEN_W   = 14;

  localparam logic [63:0] IDLE_W = 64'h0707_0707_0707_0707;
  localparam logic [63:0] PRE_W  = 64'hD555_5555_5555_55FB;

  logic             clk156 = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic             enable = 1'b0;
  logic [31:0]      frame_count = 32'd1;
  logic [LEN_W-1:0] frame_len = 14'd64;
  logic [7:0]       ifg_words = 8'd1;
  logic [47:0]      dst_mac = 48'h02_00_5E_10_20_30;
  logic [47:0]      src_mac = 48'h00_1B_21_AB_CD_EF;
  logic [15:0]      ethertype = 16'h88B5;
  logic [63:0]      xgmii_txd;
  logic [7:0]       xgmii_txc;
  logic             busy;
  logic             done;
  logic [31:0]      frames_sent;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] eb [0:9215];
  logic [7:0] last_txc;

  xgmii_frame_gen #(
    .MIN_LEN (MIN_LEN),
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) dut (
    .clk156      (clk156),
    .sys_rst_n   (sys_rst_n),
    .enable      (enable),
    .frame_count (frame_count),
    .frame_len   (frame_len),
    .ifg_words   (ifg_words),
    .dst_mac     (dst_mac),
    .src_mac     (src_mac),
    .ethertype   (ethertype),
    .xgmii_txd   (xgmii_txd),
    .xgmii_txc   (xgmii_txc),
    .busy        (busy),
    .done        (done),
    .frames_sent (frames_sent)
  );

  always #3.2 clk156 = ~clk156;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference CRC-32 over eb[0..n-1].
  function automatic logic [31:0] crc32_eb(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, eb[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Expected frame bytes for the current field settings.
  task automatic build_frame(input int len, input logic [31:0] seq);
    logic [31:0] f;
    for (int i = 0; i < 6; i++) eb[i]      = dst_mac[47-8*i -: 8];
    for (int i = 0; i < 6; i++) eb[6+i]    = src_mac[47-8*i -: 8];
    for (int i = 0; i < 2; i++) eb[12+i]   = ethertype[15-8*i -: 8];
    for (int i = 0; i < 4; i++) eb[14+i]   = seq[31-8*i -: 8];
    for (int k = 18; k < len - 4; k++) eb[k] = 8'(k - 18);
    f = crc32_eb(len - 4);
    eb[len-4] = f[7:0];
    eb[len-3] = f[15:8];
    eb[len-2] = f[23:16];
    eb[len-1] = f[31:24];
  endtask

  // Wait for the preamble word; exp_n is the expected number of negedges.
  task automatic wait_pre(input string tag, input int budget, input int exp_n);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    while (n < budget && !seen) begin
      @(negedge clk156);
      n++;
      if (xgmii_txd == PRE_W && xgmii_txc == 8'h01) seen = 1'b1;
    end
    check({tag, " pre latency"}, 80'(n), 80'(exp_n));
    check({tag, " pre busy"}, 80'(busy), 80'(1));
  endtask

  // Compare every data word of one frame, PRE already on the outputs.
  task automatic check_frame(input string tag, input int len, input logic [31:0] seq,
                             input int drop_at);
    int          nw;
    int          k;
    logic [63:0] ed;
    logic [7:0]  ec;
    build_frame(len, seq);
    nw = (len + 8) / 8;
    for (int w = 0; w < nw; w++) begin
      @(negedge clk156);
      for (int l = 0; l < 8; l++) begin
        k = w * 8 + l;
        if (k < len) begin
          ed[8*l +: 8] = eb[k];
          ec[l]        = 1'b0;
        end else if (k == len) begin
          ed[8*l +: 8] = 8'hFD;
          ec[l]        = 1'b1;
        end else begin
          ed[8*l +: 8] = 8'h07;
          ec[l]        = 1'b1;
        end
      end
      check($sformatf("%s word%0d", tag, w), 80'({xgmii_txc, xgmii_txd}), 80'({ec, ed}));
      last_txc = xgmii_txc;
      if (w == drop_at) enable = 1'b0;
    end
  endtask

  task automatic check_ifg(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk156);
      check($sformatf("%s ifg%0d", tag, i), 80'({busy, xgmii_txc, xgmii_txd}),
            80'({1'b1, 8'hFF, IDLE_W}));
    end
  endtask

  task automatic check_end(input string tag, input logic d, input logic [31:0] fs);
    @(negedge clk156);
    check({tag, " end flags"}, 80'({busy, done, frames_sent}), 80'({1'b0, d, fs}));
  endtask

  initial begin
    int nonidle;

    // CRC model against the standard "123456789" check value.
    for (int i = 0; i < 9; i++) eb[i] = 8'(8'h31 + i);
    check("crc model", 80'(crc32_eb(9)), 80'(32'hCBF4_3926));

    // Reset state.
    repeat (3) @(negedge clk156);
    check("reset txd", 80'(xgmii_txd), 80'(IDLE_W));
    check("reset txc", 80'(xgmii_txc), 80'(8'hFF));
    check("reset flags", 80'({busy, done, frames_sent}), 80'(0));
    sys_rst_n = 1'b1;
    @(negedge clk156);

    // Basic 64-byte frame.
    enable = 1'b1;
    wait_pre("basic", 10, 2);
    check_frame("basic", 64, 32'd0, -1);
    check("basic term txc", 80'(last_txc), 80'(8'hFF));
    check_ifg("basic", 1);
    check_end("basic", 1'b1, 32'd1);

    // Holding enable after done sends nothing more.
    nonidle = 0;
    repeat (20) begin
      @(negedge clk156);
      if (xgmii_txc != 8'hFF) nonidle++;
    end
    check("rearm hold", 80'(nonidle), 80'(0));
    check("rearm done held", 80'({done, frames_sent}), 80'({1'b1, 32'd1}));
    enable = 1'b0;
    @(negedge clk156);
    check("rearm clear", 80'({done, frames_sent}), 80'(0));
    enable = 1'b1;
    wait_pre("rearm", 10, 2);
    check_frame("rearm", 64, 32'd0, -1);
    check_ifg("rearm", 1);
    check_end("rearm", 1'b1, 32'd1);

    // Odd length, longer gap, two frames.
    enable = 1'b0;
    frame_len = 14'd67;
    ifg_words = 8'd3;
    frame_count = 32'd2;
    @(negedge clk156);
    enable = 1'b1;
    wait_pre("odd1", 10, 2);
    check_frame("odd1", 67, 32'd0, -1);
    check("odd term txc", 80'(last_txc), 80'(8'hF8));
    check_ifg("odd1", 3);
    wait_pre("odd2", 1, 1);
    check("odd2 sent", 80'(frames_sent), 80'(32'd1));
    check_frame("odd2", 67, 32'd1, -1);
    check_ifg("odd2", 3);
    check_end("odd2", 1'b1, 32'd2);

    // Length clamped up.
    enable = 1'b0;
    frame_len = 14'd10;
    ifg_words = 8'd0;
    frame_count = 32'd1;
    @(negedge clk156);
    enable = 1'b1;
    wait_pre("clamp lo", 10, 2);
    check_frame("clamp lo", 64, 32'd0, -1);
    check_ifg("clamp lo", 1);
    check_end("clamp lo", 1'b1, 32'd1);

    // Length clamped down.
    enable = 1'b0;
    frame_len = 14'd2000;
    ifg_words = 8'd1;
    @(negedge clk156);
    enable = 1'b1;
    wait_pre("clamp hi", 10, 2);
    check_frame("clamp hi", 1518, 32'd0, -1);
    check_ifg("clamp hi", 1);
    check_end("clamp hi", 1'b1, 32'd1);

    // Infinite run, enable dropped inside the fifth frame.
    enable = 1'b0;
    frame_len = 14'd64;
    ifg_words = 8'd2;
    frame_count = 32'd0;
    @(negedge clk156);
    enable = 1'b1;
    wait_pre("inf0", 10, 2);
    for (int f = 0; f < 5; f++) begin
      check_frame($sformatf("inf%0d", f), 64, 32'(f), (f == 4) ? 3 : -1);
      check_ifg($sformatf("inf%0d", f), 2);
      if (f < 4) wait_pre($sformatf("inf%0d", f + 1), 1, 1);
    end
    check_end("inf", 1'b0, 32'd5);
    @(negedge clk156);
    check("inf cleared", 80'({busy, done, frames_sent, xgmii_txc}), 80'({2'b00, 32'd0, 8'hFF}));

    // Reset pulse in the middle of the second frame of a two-frame run.
    frame_count = 32'd2;
    ifg_words = 8'd1;
    enable = 1'b1;
    wait_pre("rst a", 10, 2);
    check_frame("rst a", 64, 32'd0, -1);
    check_ifg("rst a", 1);
    wait_pre("rst b", 1, 1);
    repeat (3) @(negedge clk156);
    check("rst in data", 80'(xgmii_txc), 80'(8'h00));
    #1 sys_rst_n = 1'b0;
    #1;
    check("rst async out", 80'({busy, xgmii_txc, xgmii_txd}), 80'({1'b0, 8'hFF, IDLE_W}));
    check("rst async flags", 80'({done, frames_sent}), 80'(0));
    @(negedge clk156);
    sys_rst_n = 1'b1;
    wait_pre("rst c", 10, 2);
    check_frame("rst c", 64, 32'd0, -1);
    check_ifg("rst c", 1);
    wait_pre("rst d", 1, 1);
    check_frame("rst d", 64, 32'd1, -1);
    check_ifg("rst d", 1);
    check_end("rst d", 1'b1, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
